seg_display_scanner: RTL and testbench

Downstream consumer of digital_clock's six seven-segment patterns (d_6..d_1) and its indicator output. Time-multiplexes the six digits onto one shared segment bus with one-hot digit enables for a common-segment LED board. Snapshots all six patterns once per scan frame so a frame never mixes two clock values. Blinks the whole display while indicator is high.

---
 rtl/seg_display_scanner.sv | 124 ++++++++++++
 tb/tb_seg_display_scanner.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/seg_display_scanner.sv
// Six-digit seven-segment scanner: snapshots d_1..d_6 once per frame and walks them
// onto a shared segment bus with one-hot digit enables, blanking and blinking on demand.
module seg_display_scanner #(
    parameter int SCAN_DIV       = 4,
    parameter int BLINK_FRAMES   = 2,
    parameter int LZB            = 1,
    parameter int SEG_ACTIVE_LOW = 0,
    parameter int AN_ACTIVE_LOW  = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] d_1,
    input  logic [6:0] d_2,
    input  logic [6:0] d_3,
    input  logic [6:0] d_4,
    input  logic [6:0] d_5,
    input  logic [6:0] d_6,
    input  logic       indicator,
    output logic [6:0] seg,
    output logic [5:0] an,
    output logic       frame_tick
);

    localparam int              DW           = $clog2(SCAN_DIV);
    localparam int              BW           = $clog2(BLINK_FRAMES + 1);
    localparam logic [DW-1:0]   DIV_LAST     = DW'(SCAN_DIV - 1);
    localparam logic [BW-1:0]   BLINK_LAST   = BW'(BLINK_FRAMES - 1);
    localparam logic [2:0]      LAST_DIGIT   = 3'd5;
    localparam logic [6:0]      ZERO_PATTERN = 7'h3F;
    localparam logic [6:0]      SEG_OFF      = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
    localparam logic [5:0]      AN_OFF       = (AN_ACTIVE_LOW != 0) ? 6'h3F : 6'h00;

    logic [DW-1:0] div_cnt;
    logic [2:0]    digit_sel;
    logic [BW-1:0] blink_cnt;
    logic          blink_phase;
    logic [6:0]    d_in [6];
    logic [6:0]    snap [6];
    logic [6:0]    snap_sel;
    logic          frame_end;
    logic          blank;
    logic          lz_blank;
    logic [6:0]    seg_int;
    logic [5:0]    an_int;

    always_comb begin
        d_in[0] = d_1;
        d_in[1] = d_2;
        d_in[2] = d_3;
        d_in[3] = d_4;
        d_in[4] = d_5;
        d_in[5] = d_6;
    end

    always_comb begin
        // NOTE: every path assigns snap_sel, so no latch is inferred for unused codes 6/7.
        unique case (digit_sel)
            3'd0:    snap_sel = snap[0];
            3'd1:    snap_sel = snap[1];
            3'd2:    snap_sel = snap[2];
            3'd3:    snap_sel = snap[3];
            3'd4:    snap_sel = snap[4];
            3'd5:    snap_sel = snap[5];
            default: snap_sel = 7'h00;
        endcase
    end

    always_comb begin
        frame_end = (div_cnt == DIV_LAST) && (digit_sel == LAST_DIGIT);
        lz_blank  = (LZB != 0) && (digit_sel == LAST_DIGIT) && (snap[5] == ZERO_PATTERN);
        blank     = indicator && blink_phase;
        seg_int   = (blank || lz_blank) ? 7'h00 : snap_sel;
        an_int    = 6'd1 << digit_sel;
    end

    // NOTE: the snapshot is not cleared by reset; it tracks the inputs instead so the
    // first frame after release already shows live data.
    always_ff @(posedge clk) begin
        if (reset || frame_end) begin
            for (int i = 0; i < 6; i++) begin
                snap[i] <= d_in[i];
            end
        end
    end

    // NOTE: all state below uses non-blocking assignments so every register samples
    // the pre-edge value of its neighbours.
    always_ff @(posedge clk) begin
        if (reset) begin
            div_cnt     <= '0;
            digit_sel   <= '0;
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
            seg         <= SEG_OFF;
            an          <= AN_OFF;
            frame_tick  <= 1'b0;
        end else begin
            if (div_cnt == DIV_LAST) begin
                div_cnt   <= '0;
                digit_sel <= (digit_sel == LAST_DIGIT) ? 3'd0 : digit_sel + 3'd1;
            end else begin
                div_cnt <= div_cnt + 1'b1;
            end

            if (!indicator) begin
                blink_cnt   <= '0;
                blink_phase <= 1'b0;
            end else if (frame_end) begin
                if (blink_cnt == BLINK_LAST) begin
                    blink_cnt   <= '0;
                    blink_phase <= ~blink_phase;
                end else begin
                    blink_cnt <= blink_cnt + 1'b1;
                end
            end

            // XOR with the off level flips polarity only at the pins.
            seg        <= seg_int ^ SEG_OFF;
            an         <= an_int ^ AN_OFF;
            frame_tick <= frame_end;
        end
    end

endmodule

// File: tb/tb_seg_display_scanner.sv
// Randomized bench for seg_display_scanner: two instances (default and LZB=0 with
// inverted polarity) checked each cycle against a time-indexed reference model.
module tb_seg_display_scanner;

    localparam int SD = 4;
    localparam int BF = 2;
    localparam int FRAME = 6 * SD;

    logic       clk = 1'b0;
    logic       reset;
    logic       indicator;
    logic [6:0] d [6];
    logic [6:0] seg_a, seg_b;
    logic [5:0] an_a, an_b;
    logic       tick_a, tick_b;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    seg_display_scanner #(
        .SCAN_DIV(SD), .BLINK_FRAMES(BF), .LZB(1), .SEG_ACTIVE_LOW(0), .AN_ACTIVE_LOW(0)
    ) dut_a (
        .clk(clk), .reset(reset),
        .d_1(d[0]), .d_2(d[1]), .d_3(d[2]), .d_4(d[3]), .d_5(d[4]), .d_6(d[5]),
        .indicator(indicator), .seg(seg_a), .an(an_a), .frame_tick(tick_a)
    );

    seg_display_scanner #(
        .SCAN_DIV(SD), .BLINK_FRAMES(BF), .LZB(0), .SEG_ACTIVE_LOW(1), .AN_ACTIVE_LOW(1)
    ) dut_b (
        .clk(clk), .reset(reset),
        .d_1(d[0]), .d_2(d[1]), .d_3(d[2]), .d_4(d[3]), .d_5(d[4]), .d_6(d[5]),
        .indicator(indicator), .seg(seg_b), .an(an_b), .frame_tick(tick_b)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: position in the display is derived from the number of clock
    // edges since reset; the blink phase from the number of frames seen with indicator high.
    int         t = 0;
    int         frames_high = 0;
    logic [6:0] m_snap [6];
    logic [6:0] e_seg_a, e_seg_b;
    logic [5:0] e_an_a, e_an_b;
    logic       e_tick;
    bit         m_valid = 0;

    always @(posedge clk) begin : ref_model
        int         digit;
        bit         fe;
        bit         blk;
        logic [6:0] raw;
        if (reset) begin
            t = 0;
            frames_high = 0;
            for (int i = 0; i < 6; i++) m_snap[i] = d[i];
            e_seg_a = 7'h00; e_seg_b = 7'h7F;
            e_an_a  = 6'h00; e_an_b  = 6'h3F;
            e_tick  = 1'b0;
        end else begin
            digit   = (t / SD) % 6;
            fe      = (t % FRAME) == FRAME - 1;
            blk     = indicator && (((frames_high / BF) % 2) == 1);
            raw     = m_snap[digit];
            e_seg_a = (blk || (digit == 5 && raw == 7'h3F)) ? 7'h00 : raw;
            e_seg_b = blk ? 7'h7F : ~raw;
            e_an_a  = 6'(1 << digit);
            e_an_b  = ~e_an_a;
            e_tick  = fe;
            if (!indicator) frames_high = 0;
            else if (fe) frames_high++;
            if (fe) for (int i = 0; i < 6; i++) m_snap[i] = d[i];
            t++;
        end
        m_valid = 1;
    end

    always @(negedge clk) begin
        if (m_valid) begin
            check("seg_a", seg_a, e_seg_a);
            check("an_a", an_a, e_an_a);
            check("tick_a", tick_a, e_tick);
            check("seg_b", seg_b, e_seg_b);
            check("an_b", an_b, e_an_b);
            check("tick_b", tick_b, e_tick);
        end
    end

    function automatic logic [6:0] rand_pat();
        if ($urandom_range(3) == 0) return 7'h3F;
        return 7'($urandom_range(1, 127));
    endfunction

    task automatic run_random(input int n);
        repeat (n) begin
            @(negedge clk);
            if ($urandom_range(7) == 0) d[$urandom_range(5)] = rand_pat();
        end
    endtask

    initial begin
        reset = 1'b1;
        indicator = 1'b0;
        d[0] = 7'h06; d[1] = 7'h02; d[2] = 7'h04;
        d[3] = 7'h08; d[4] = 7'h10; d[5] = 7'h20;
        repeat (3) @(negedge clk);
        check("rst_seg", seg_a, 7'h00);
        check("rst_an", an_a, 6'h00);
        check("rst_tick", tick_a, 1'b0);

        reset = 1'b0;
        d[0] = 7'h01;
        #1;
        check("rel1_seg", seg_a, 7'h00);
        check("rel1_an", an_a, 6'h00);
        @(negedge clk);
        check("rel2_an", an_a, 6'b000001);
        check("rel2_seg", seg_a, 7'h06);

        // Fixed walking patterns, then a mid-frame change of d_3.
        repeat (FRAME * 2) @(negedge clk);
        d[2] = 7'h7F;
        repeat (FRAME * 2) @(negedge clk);

        // Leading-zero digit on both instances.
        d[5] = 7'h3F;
        repeat (FRAME * 2) @(negedge clk);
        d[5] = 7'h06;
        repeat (FRAME) @(negedge clk);

        // Blink: raise indicator at a frame start, drop it inside the second blank window.
        begin : blink_test
            int k;
            for (k = 0; k < 2 * FRAME && !tick_a; k++) @(negedge clk);
            check("tick_wait", tick_a, 1'b1);
            for (int i = 0; i < 6; i++) d[i] = 7'($urandom_range(1, 127));
            indicator = 1'b1;
            repeat (6 * FRAME + 8) @(negedge clk);
            check("blank_seg", seg_a, 7'h00);
            indicator = 1'b0;
            @(negedge clk);
            check("unblank", seg_a != 7'h00, 1'b1);
        end

        // Random data and indicator activity.
        for (int i = 0; i < 25; i++) begin
            indicator = 1'($urandom_range(1));
            run_random($urandom_range(10, 150));
        end
        indicator = 1'b0;

        // Reset mid-frame while digit 3 is lit.
        for (int r = 0; r < 4; r++) begin
            int k;
            run_random($urandom_range(5, 60));
            for (k = 0; k < 2 * FRAME && an_a != 6'b001000; k++) @(negedge clk);
            check("mid_wait", an_a, 6'b001000);
            indicator = 1'($urandom_range(1));
            reset = 1'b1;
            for (int i = 0; i < 6; i++) d[i] = rand_pat();
            @(negedge clk);
            check("mid_seg", seg_a, 7'h00);
            check("mid_an", an_a, 6'h00);
            check("mid_tick", tick_a, 1'b0);
            reset = 1'b0;
            @(negedge clk);
            check("mid_restart", an_a, 6'b000001);
        end
        run_random(FRAME * 3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
